// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: EX/MEM register, req/ack load/store unit with timeout, and MEM/WB register.
module mem_stage_lsu #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_dmem_wen,
  input  logic        ex_dmem_ren,
  input  logic [1:0]  ex_size,
  input  logic        ex_load_signed,
  input  logic        ex_reg_wen,
  input  logic [4:0]  ex_reg_waddr,
  output logic        mem_stall,
  output logic [31:0] mem_fwd_data,
  output logic        mem_reg_wen,
  output logic [4:0]  mem_reg_waddr,
  output logic        mem_dmem_ren,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_reg_wen,
  output logic [4:0]  wb_reg_waddr,
  output logic [31:0] wb_data,
  output logic        mem_misalign,
  output logic        mem_bus_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [7:0] TIMEOUT = 8'(ACK_TIMEOUT);
  state_t state;
  logic [31:0] addr, storeData, laneData, loadData;
  logic [1:0] size;
  logic [7:0] waitCnt;
  logic memWen, loadSigned, misalignQ, busErrQ;
  logic exMemOp, exMisalign, timeout;
  always_comb begin
    exMemOp = ex_valid && (ex_dmem_wen || ex_dmem_ren);
    exMisalign = exMemOp && ((ex_size == 2'b01 && ex_alu_result[0]) ||
                             (ex_size[1] && ex_alu_result[1:0] != 2'b00));
    timeout = state == WAIT && !dmem_ack && waitCnt == TIMEOUT;
    mem_stall = state == WAIT && !dmem_ack && !timeout;
    dmem_req = state == WAIT;
    dmem_we = memWen;
    dmem_addr = {addr[31:2], 2'b00};
    dmem_be = size == 2'b00 ? 4'b0001 << addr[1:0] :
              size == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
    dmem_wdata = size == 2'b00 ? {4{storeData[7:0]}} :
                 size == 2'b01 ? {2{storeData[15:0]}} : storeData;
    laneData = dmem_rdata >> {addr[1:0], 3'b000};
    loadData = size == 2'b00 ? {{24{loadSigned && laneData[7]}}, laneData[7:0]} :
               size == 2'b01 ? {{16{loadSigned && laneData[15]}}, laneData[15:0]} : dmem_rdata;
    mem_fwd_data = addr;
    mem_misalign = misalignQ;
    mem_bus_err = busErrQ;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      storeData <= '0;
      size <= '0;
      loadSigned <= 1'b0;
      memWen <= 1'b0;
      mem_dmem_ren <= 1'b0;
      mem_reg_wen <= 1'b0;
      mem_reg_waddr <= '0;
      waitCnt <= '0;
      misalignQ <= 1'b0;
      busErrQ <= 1'b0;
      wb_reg_wen <= 1'b0;
      wb_reg_waddr <= '0;
      wb_data <= '0;
    end else begin
      if (!mem_stall) begin
        addr <= ex_alu_result;
        storeData <= ex_store_data;
        size <= ex_size;
        loadSigned <= ex_load_signed;
        memWen <= exMemOp && !exMisalign && ex_dmem_wen;
        mem_dmem_ren <= exMemOp && !exMisalign && ex_dmem_ren;
        mem_reg_wen <= ex_valid && ex_reg_wen && !exMisalign;
        mem_reg_waddr <= ex_reg_waddr;
        state <= exMemOp && !exMisalign ? WAIT : IDLE;
        wb_reg_waddr <= mem_reg_waddr;
        wb_data <= mem_dmem_ren ? loadData : addr;
      end
      // a timed-out access releases the stall but must not write back
      wb_reg_wen <= !mem_stall && !timeout && mem_reg_wen;
      misalignQ <= !mem_stall && exMisalign;
      busErrQ <= timeout;
      waitCnt <= mem_stall ? waitCnt + 8'd1 : 8'd0;
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed plan steps plus random loads/stores against a byte-array memory model.
module tb_mem_stage_lsu;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ex_valid, ex_dmem_wen, ex_dmem_ren, ex_load_signed, ex_reg_wen, dmem_ack;
  logic [31:0] ex_alu_result, ex_store_data, dmem_rdata;
  logic [1:0] ex_size;
  logic [4:0] ex_reg_waddr;
  logic mem_stall, mem_reg_wen, mem_dmem_ren, dmem_req, dmem_we, wb_reg_wen, mem_misalign, mem_bus_err;
  logic [31:0] mem_fwd_data, dmem_addr, dmem_wdata, wb_data;
  logic [4:0] mem_reg_waddr, wb_reg_waddr;
  logic [3:0] dmem_be;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_stage_lsu #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_dmem_wen(ex_dmem_wen), .ex_dmem_ren(ex_dmem_ren),
    .ex_size(ex_size), .ex_load_signed(ex_load_signed), .ex_reg_wen(ex_reg_wen),
    .ex_reg_waddr(ex_reg_waddr), .mem_stall(mem_stall), .mem_fwd_data(mem_fwd_data),
    .mem_reg_wen(mem_reg_wen), .mem_reg_waddr(mem_reg_waddr), .mem_dmem_ren(mem_dmem_ren),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_reg_wen(wb_reg_wen), .wb_reg_waddr(wb_reg_waddr), .wb_data(wb_data),
    .mem_misalign(mem_misalign), .mem_bus_err(mem_bus_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic setEx(input logic v, input logic [31:0] alu, input logic [31:0] sd, input logic w,
                       input logic r, input logic [1:0] sz, input logic sg, input logic rw,
                       input logic [4:0] wa);
    ex_valid = v; ex_alu_result = alu; ex_store_data = sd; ex_dmem_wen = w; ex_dmem_ren = r;
    ex_size = sz; ex_load_signed = sg; ex_reg_wen = rw; ex_reg_waddr = wa;
  endtask
  task automatic bubble();
    setEx(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
  endtask
  logic [7:0] mem [64];
  initial begin
    int cnt, kind, n, off, base, delay;
    logic [31:0] a, sd, expWd, rd, v;
    logic [3:0] expBe;
    logic [1:0] sz;
    logic sg, rw, mis;
    logic [4:0] wa;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    bubble();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    #12;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_wbwen", 32'(wb_reg_wen), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_fwd", mem_fwd_data, 32'd0);
    chk("rst_flags", {30'd0, mem_misalign, mem_bus_err}, 32'd0);
    rst_n = 1'b1;
    tick();
    // ALU op
    setEx(1'b1, 32'h12345678, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd5);
    #1 chk("alu_stall0", 32'(mem_stall), 32'd0);
    tick();
    bubble();
    chk("alu_fwd", mem_fwd_data, 32'h12345678);
    chk("alu_memwen", {26'd0, mem_reg_wen, mem_reg_waddr}, {26'd0, 1'b1, 5'd5});
    chk("alu_stall1", 32'(mem_stall), 32'd0);
    tick();
    chk("alu_wbdata", wb_data, 32'h12345678);
    chk("alu_wbwen", {26'd0, wb_reg_wen, wb_reg_waddr}, {26'd0, 1'b1, 5'd5});
    // lb signed at 0x1003, ack after 3 stall cycles
    setEx(1'b1, 32'h1003, 32'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 5'd6);
    tick();
    bubble();
    chk("lb_req", 32'(dmem_req), 32'd1);
    chk("lb_be", 32'(dmem_be), 32'b1000);
    chk("lb_addr", dmem_addr, 32'h1000);
    chk("lb_we", 32'(dmem_we), 32'd0);
    chk("lb_memren", 32'(mem_dmem_ren), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("lb_stall", 32'(mem_stall), 32'd1);
      tick();
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h80AABBCC;
    #1 chk("lb_stall_ack", 32'(mem_stall), 32'd0);
    tick();
    dmem_ack = 1'b0;
    chk("lb_wbdata", wb_data, 32'hFFFFFF80);
    chk("lb_wbwen", 32'(wb_reg_wen), 32'd1);
    chk("lb_req_off", 32'(dmem_req), 32'd0);
    // sh at 0x2002
    setEx(1'b1, 32'h2002, 32'h0000BEEF, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 5'd0);
    tick();
    bubble();
    chk("sh_be", 32'(dmem_be), 32'b1100);
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    chk("sh_we", 32'(dmem_we), 32'd1);
    chk("sh_addr", dmem_addr, 32'h2000);
    dmem_ack = 1'b1;
    #1 chk("sh_stall", 32'(mem_stall), 32'd0);
    tick();
    dmem_ack = 1'b0;
    chk("sh_wbwen", 32'(wb_reg_wen), 32'd0);
    // misaligned lw
    setEx(1'b1, 32'h0001, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 5'd7);
    tick();
    bubble();
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_pulse", 32'(mem_misalign), 32'd1);
    chk("mis_memwen", {30'd0, mem_reg_wen, mem_dmem_ren}, 32'd0);
    tick();
    chk("mis_pulse_end", 32'(mem_misalign), 32'd0);
    chk("mis_wbwen", 32'(wb_reg_wen), 32'd0);
    // timeout with ACK_TIMEOUT = 4
    setEx(1'b1, 32'h0040, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 5'd9);
    tick();
    bubble();
    cnt = 0;
    while (dmem_req && cnt < 10) begin
      cnt++;
      chk("to_stall", 32'(mem_stall), 32'(cnt < 5));
      tick();
    end
    chk("to_req_cycles", 32'(cnt), 32'd5);
    chk("to_buserr", 32'(mem_bus_err), 32'd1);
    chk("to_wbwen", 32'(wb_reg_wen), 32'd0);
    tick();
    chk("to_buserr_end", 32'(mem_bus_err), 32'd0);
    // back-to-back lw/lw
    setEx(1'b1, 32'h0100, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 5'd3);
    tick();
    setEx(1'b1, 32'h0104, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 5'd4);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h11111111;
    #1 chk("b2b_req1", {30'd0, dmem_req, mem_stall}, 32'b10);
    tick();
    bubble();
    dmem_rdata = 32'h22222222;
    #1 chk("b2b_req2", {30'd0, dmem_req, mem_stall}, 32'b10);
    chk("b2b_addr2", dmem_addr, 32'h0104);
    chk("b2b_wb1", wb_data, 32'h11111111);
    chk("b2b_wbaddr1", 32'(wb_reg_waddr), 32'd3);
    tick();
    dmem_ack = 1'b0;
    chk("b2b_wb2", wb_data, 32'h22222222);
    chk("b2b_wbaddr2", 32'(wb_reg_waddr), 32'd4);
    chk("b2b_req_off", 32'(dmem_req), 32'd0);
    // asynchronous reset mid-WAIT
    setEx(1'b1, 32'h0200, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 5'd2);
    tick();
    bubble();
    chk("ar_req_on", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("ar_req_off", 32'(dmem_req), 32'd0);
    chk("ar_stall", 32'(mem_stall), 32'd0);
    rst_n = 1'b1;
    tick();
    // random phase against the byte-array memory model
    for (int it = 0; it < 300; it++) begin
      kind = $urandom_range(0, 3);
      a = 32'h300 + 32'($urandom_range(0, 63));
      sd = $urandom;
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom);
      rw = 1'($urandom);
      wa = 5'($urandom);
      delay = $urandom_range(0, 5);
      n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
      off = int'(a[1:0]);
      base = int'(a[5:0]) & 32'h3C;
      mis = (kind == 1 || kind == 2) && ((n == 2 && a[0]) || (n == 4 && off != 0));
      for (int i = 0; i < 4; i++) begin
        expBe[i] = i >= off && i < off + n;
        expWd[8*i +: 8] = sd[8*(i % n) +: 8];
      end
      if (kind == 0) setEx(1'b1, a, sd, 1'b0, 1'b0, sz, sg, rw, wa);
      else if (kind == 1) setEx(1'b1, a, sd, 1'b0, 1'b1, sz, sg, rw, wa);
      else if (kind == 2) setEx(1'b1, a, sd, 1'b1, 1'b0, sz, sg, 1'b0, wa);
      else setEx(1'b0, a, sd, 1'($urandom), 1'($urandom), sz, sg, rw, wa);
      tick();
      bubble();
      if (kind == 0 || kind == 3) begin
        chk("r_fwd_req", {30'd0, dmem_req, mem_stall}, 32'd0);
        chk("r_memwen", 32'(mem_reg_wen), 32'(kind == 0 && rw));
        if (kind == 0) chk("r_fwd", mem_fwd_data, a);
        tick();
        chk("r_wbwen", 32'(wb_reg_wen), 32'(kind == 0 && rw));
        if (kind == 0 && rw) chk("r_wbdata", wb_data, a);
      end else if (mis) begin
        chk("r_mis", {30'd0, dmem_req, mem_misalign}, 32'b01);
        tick();
        chk("r_mis_wb", {30'd0, wb_reg_wen, mem_misalign}, 32'd0);
      end else begin
        chk("r_req", {30'd0, dmem_req, dmem_we}, {30'd0, 1'b1, kind == 2});
        chk("r_addr", dmem_addr, {a[31:2], 2'b00});
        chk("r_be", 32'(dmem_be), 32'(expBe));
        if (kind == 2) chk("r_wdata", dmem_wdata, expWd);
        for (int c = 0; c < delay && c < 5; c++) begin
          chk("r_stall", 32'(mem_stall), 32'(c < 4));
          chk("r_addr_hold", dmem_addr, {a[31:2], 2'b00});
          tick();
        end
        if (delay < 5) begin
          for (int i = 0; i < 4; i++) rd[8*i +: 8] = mem[base + i];
          v = 32'h0;
          for (int k = 0; k < n; k++) v[8*k +: 8] = mem[base + off + k];
          if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
          dmem_ack = 1'b1;
          dmem_rdata = rd;
          #1 chk("r_ack_stall", 32'(mem_stall), 32'd0);
          tick();
          dmem_ack = 1'b0;
          dmem_rdata = $urandom;
          chk("r_ack_wbwen", 32'(wb_reg_wen), 32'(kind == 1 && rw));
          if (kind == 1) chk("r_load", wb_data, v);
          if (kind == 2)
            for (int i = 0; i < 4; i++) if (expBe[i]) mem[base + i] = expWd[8*i +: 8];
          chk("r_no_err", 32'(mem_bus_err), 32'd0);
        end else begin
          chk("r_to", {29'd0, dmem_req, mem_bus_err, wb_reg_wen}, 32'b010);
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM pipeline stage: EX/MEM pipeline register, load/store unit and MEM/WB pipeline register.
- Consumes the EX-stage outputs (ALU result, bypassed store data, write-back control) and drives a req/ack data-memory bus.
- Sources the EX/MEM forwarding data and control (write enable, write address, read enable) back to EX, and issues a stall while a memory access is outstanding.

Parameters:
ACK_TIMEOUT, 255, cycles waited for dmem_ack before aborting the access with a bus error (1..255)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX holds a valid instruction
ex_alu_result  in  32  ALU result; effective address for loads/stores
ex_store_data  in  32  bypassed store data
ex_dmem_wen  in  1  store
ex_dmem_ren  in  1  load
ex_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
ex_load_signed  in  1  sign-extend sub-word loads
ex_reg_wen  in  1  instruction writes the register file
ex_reg_waddr  in  5  destination register
mem_stall  out  1  EX and earlier stages hold this cycle
mem_fwd_data  out  32  EX/MEM forwarding data (registered ALU result)
mem_reg_wen  out  1  EX/MEM register-write enable, for forwarding
mem_reg_waddr  out  5  EX/MEM destination register, for forwarding
mem_dmem_ren  out  1  EX/MEM holds a load (load-use stall detect in EX)
dmem_req  out  1  memory request
dmem_we  out  1  1 store, 0 load
dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  access complete; rdata valid this cycle
dmem_rdata  in  32  read data
wb_reg_wen  out  1  MEM/WB register-write enable
wb_reg_waddr  out  5  MEM/WB destination register
wb_data  out  32  MEM/WB write-back data
mem_misalign  out  1  1-cycle pulse: misaligned access dropped
mem_bus_err  out  1  1-cycle pulse: access timed out

Behaviour:
- Reset (async): all registers, outputs and counter = 0; FSM state = IDLE; dmem_req drops immediately, including mid-access.
- EX/MEM register loads ex_* on each rising edge when mem_stall = 0; holds when mem_stall = 1.
- If ex_valid = 0, the register loads a bubble (all enables 0).
- Misalignment check at capture: half with addr[0] = 1, or word with addr[1:0] != 0.
  - The instruction is captured with dmem/reg enables cleared.
  - mem_misalign pulses in the following cycle.
  - No request is issued.
- FSM:
  - IDLE: stage register holds no memory op.
  - WAIT: stage register holds an aligned load/store.
  - Entry to WAIT is on the capture edge.
- In WAIT:
  - dmem_req = 1.
  - mem_stall = !dmem_ack.
  - The 8-bit wait counter increments on each cycle without ack.
- On dmem_ack in WAIT:
  - MEM/WB register is loaded on that edge.
  - The next instruction is captured on the same edge.
  - Next state is WAIT if the new instruction is an aligned memory op, else IDLE.
  - Counter clears.
  - Back-to-back accesses therefore incur no idle cycle.
- Timeout: counter == ACK_TIMEOUT with no ack → abort.
  - mem_bus_err pulses next cycle.
  - Register write is suppressed.
  - Stall releases this cycle.
  - Counter clears.
- dmem_ack in IDLE is ignored.
- Bubble rule: while mem_stall = 1, the MEM/WB register loads wb_reg_wen = 0 (no duplicate write-back).
- Non-memory instructions: wb_data = ALU result; latency 1 cycle EX/MEM → MEM/WB.
- Store byte enables and data:
  - Byte: be = 0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - Half: be = 0011 << addr[1:0]; wdata = {2{data[15:0]}}.
  - Word: be = 1111; wdata = data.
- Load lane selection is little-endian by addr[1:0]. Extension: ex_load_signed = 1 → sign-extend; 0 → zero-extend. Loads use dmem_be as for stores.
- Register-file write on loads: the write to $0 is still performed if requested; EX ignores $0 for forwarding.
- dmem_addr, dmem_we, dmem_be and dmem_wdata are stable throughout WAIT.

Test Plan:
- ALU op (reg_waddr = 5, result 0x12345678) → mem_fwd_data = 0x12345678 one cycle later; wb_data = 0x12345678 and wb_reg_wen = 1 the cycle after; mem_stall never asserted.
- lb, signed, addr 0x1003; ack after 3 cycles with rdata 0x80AABBCC → dmem_be = 1000; mem_stall high for 3 cycles; wb_data = 0xFFFFFF80.
- sh addr 0x2002, data 0x0000BEEF → dmem_be = 1100, dmem_wdata = 0xBEEFBEEF, dmem_we = 1, addr 0x2000; wb_reg_wen = 0.
- lw addr 0x0001 → no dmem_req; mem_misalign pulses once; no register write.
- lw with ACK_TIMEOUT = 4 and no ack → req held 5 cycles then drops; mem_bus_err pulse; stall released.
- Back-to-back lw/lw, each acked immediately → req stays high 2 consecutive cycles; no stall; rst_n low mid-WAIT → dmem_req = 0 asynchronously.
